// File: rtl/por_seq_pkg.sv
// por_seq_pkg
// Shared definitions for the power-on reset sequencer: sequencer state
// encoding and the enum built from it.
package por_seq_pkg;

   localparam logic [1:0] ST_WAIT_ENC    = 2'd0;
   localparam logic [1:0] ST_HOLD_ENC    = 2'd1;
   localparam logic [1:0] ST_RELEASE_ENC = 2'd2;
   localparam logic [1:0] ST_RUN_ENC     = 2'd3;

   typedef enum logic [1:0] {
      WAIT    = ST_WAIT_ENC,
      HOLD    = ST_HOLD_ENC,
      RELEASE = ST_RELEASE_ENC,
      RUN     = ST_RUN_ENC
   } por_state_e;

endpackage

// File: rtl/por_seq_filter.sv
// por_seq_filter
// Brings the asynchronous analog POR level into the clock domain and
// removes glitches: the filtered level only follows the synchronised level
// after FILTER_CYCLES consecutive differing samples.
//
// Ports
//   clock    : system clock
//   resetb   : asynchronous active-low reset
//   async_in : asynchronous input level
//   filtered : glitch-filtered, registered level
module por_seq_filter
   import por_seq_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic clock,
   input  logic resetb,
   input  logic async_in,
   output logic filtered
);

   localparam int             CNT_W  = $clog2(FILTER_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(FILTER_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   sync_lvl;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         filtered <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         if (sync_lvl == filtered) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_TC) begin
            // this edge is the FILTER_CYCLES-th differing sample
            filtered <= sync_lvl;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/por_sequencer.sv
// por_sequencer
// Power-on reset sequencer. Filters the analog POR, holds every reset
// channel for HOLD_CYCLES after the filtered rise, then releases channels
// 0..NCH-1 one every STAGE_CYCLES. A filtered fall aborts back to WAIT.
//
// Ports
//   clock        : system clock
//   resetb       : asynchronous active-low pad reset
//   porb_in      : asynchronous analog POR, high = supply good
//   soft_rst_req : one-cycle software reset request (POR_SEQ_SOFT_RESET_EN only)
//   rst_out_n    : per-channel active-low reset, registered
//   rst_out      : per-channel active-high reset, registered
//   done         : all channels released, registered
//
// Build option: define POR_SEQ_SOFT_RESET_EN to add soft_rst_req, which in
// RUN restarts the hold-and-release sequence.
//
// state   | meaning
// --------+-----------------------------------------------------
// WAIT    | all channels in reset, waiting for filtered POR high
// HOLD    | POR good, counting the hold interval
// RELEASE | channel 0..idx-1 released, next one every STAGE_CYCLES
// RUN     | all channels released, done high
module por_sequencer
   import por_seq_pkg::*;
#(
   parameter int NCH           = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int HOLD_CYCLES   = 1000,
   parameter int STAGE_CYCLES  = 16
) (
   input  logic           clock,
   input  logic           resetb,
   input  logic           porb_in,
`ifdef POR_SEQ_SOFT_RESET_EN
   input  logic           soft_rst_req,
`endif
   output logic [NCH-1:0] rst_out_n,
   output logic [NCH-1:0] rst_out,
   output logic           done
);

   localparam int MAX_CYC = (HOLD_CYCLES > STAGE_CYCLES)
                          ? ((HOLD_CYCLES  > FILTER_CYCLES) ? HOLD_CYCLES  : FILTER_CYCLES)
                          : ((STAGE_CYCLES > FILTER_CYCLES) ? STAGE_CYCLES : FILTER_CYCLES);
   localparam int CNT_W = $clog2(MAX_CYC + 1);
   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGE_TC = CNT_W'(STAGE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] LAST_CH  = IDX_W'(NCH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam bit               HOLD_ONE = (HOLD_CYCLES == 1);
   localparam bit               ONE_CH   = (NCH == 1);

   logic             filtered;
   por_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [NCH-1:0]   rstn_d;
   logic             done_d;
   logic             rel_first;

   por_seq_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .clock    (clock),
      .resetb   (resetb),
      .async_in (porb_in),
      .filtered (filtered)
   );

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q   <= WAIT;
         cnt_q     <= '0;
         idx_q     <= '0;
         rst_out_n <= '0;
         rst_out   <= '1;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         rst_out_n <= rstn_d;
         rst_out   <= ~rstn_d;
         done      <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rstn_d    = rst_out_n;
      done_d    = done;
      rel_first = 1'b0;

      if (!filtered) begin
         state_d = WAIT;
         cnt_d   = '0;
         idx_d   = '0;
         rstn_d  = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            WAIT: begin
               // The filtered rise happened one edge before WAIT can see
               // it; that edge already counts as the first hold cycle.
               if (HOLD_ONE) begin
                  rel_first = 1'b1;
               end else begin
                  state_d = HOLD;
                  cnt_d   = CNT_ONE;
               end
            end
            HOLD: begin
               if (cnt_q == HOLD_TC) rel_first = 1'b1;
               else                  cnt_d     = cnt_q + 1'b1;
            end
            RELEASE: begin
               if (cnt_q == STAGE_TC) begin
                  rstn_d[idx_q] = 1'b1;
                  cnt_d         = '0;
                  if (idx_q == LAST_CH) begin
                     state_d = RUN;
                     done_d  = 1'b1;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            RUN: begin
`ifdef POR_SEQ_SOFT_RESET_EN
               if (soft_rst_req) begin
                  state_d = HOLD;
                  cnt_d   = '0;
                  rstn_d  = '0;
                  done_d  = 1'b0;
               end
`endif
            end
            default: begin
               state_d = WAIT;
            end
         endcase

         if (rel_first) begin
            rstn_d[0] = 1'b1;
            cnt_d     = '0;
            if (ONE_CH) begin
               state_d = RUN;
               done_d  = 1'b1;
            end else begin
               state_d = RELEASE;
               idx_d   = IDX_ONE;
            end
         end
      end
   end

endmodule
